count_window_sched: RTL and testbench
=====================================

COUNT_WINDOW_SCHED -- requirements
Module: count_window_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; SHALL be 2..8.
REQ-002 Parameter LEN_W, default 8: width of per-request window length.
REQ-003 Parameter CNT_W, default 16: width of the shared counter value.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port req_valid  input  NREQ: per-requester window request, level, held until accepted.
REQ-007 Port req_len  input  NREQ*LEN_W: window length in cycles; requester i occupies bits [i*LEN_W +: LEN_W].
REQ-008 Port req_ready  output  NREQ: one-hot single-cycle accept pulse.
REQ-009 Port abort  input  1: cancels the active window.
REQ-010 Port cnt_clr  output  1: synchronous clear strobe to the shared counter.
REQ-011 Port cnt_en  output  1: count enable to the shared counter.
REQ-012 Port cnt_val  input  CNT_W: registered counter value; reflects cnt_clr/cnt_en one cycle later.
REQ-013 Port res_valid  output  1: result available.
REQ-014 Port res_id  output  clog2(NREQ): requester index of the result.
REQ-015 Port res_data  output  CNT_W: captured count.
REQ-016 Port res_ready  input  1: result consumer ready.
REQ-017 Port busy  output  1: high in every state except IDLE.

Function
REQ-018 FSM states IDLE, CLEAR, RUN, SETTLE, REPORT; exactly one active.
REQ-019 IDLE: if any req_valid high, SHALL pulse req_ready for one winner, latch its id and req_len, go to CLEAR in the same cycle; else stay.
REQ-020 Arbitration round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on accept; reset value of last_grant is NREQ-1 (requester 0 first).
REQ-021 req_valid dropped before accept: no grant, no state change.
REQ-022 CLEAR: exactly one cycle, cnt_clr=1, cnt_en=0; next RUN, or SETTLE if latched length is 0.
REQ-023 RUN: cnt_en=1 for exactly len consecutive cycles (down-counter of width LEN_W), then SETTLE.
REQ-024 SETTLE: one cycle, cnt_en=0; at its end res_data<=cnt_val, res_id<=latched id, then REPORT.
REQ-025 Latency: accept at cycle T -> cnt_clr at T+1, cnt_en T+2..T+1+len, res_valid first high at T+3+len.
REQ-026 len=0: no cnt_en cycles; res_data SHALL be 0; res_valid at T+3.
REQ-027 len=2^LEN_W-1: full window, no length wrap.
REQ-028 REPORT: res_valid=1, res_data/res_id stable until res_valid&&res_ready; that cycle -> IDLE; no new accept in that cycle.
REQ-029 abort high in CLEAR, RUN or SETTLE: next state IDLE, cnt_en=0 next cycle, no result, last_grant retains the aborted id.
REQ-030 abort in IDLE or REPORT: ignored.
REQ-031 abort and res_ready simultaneous in REPORT: handshake completes normally.
REQ-032 req_ready SHALL never be high outside IDLE; new requests wait while busy.
REQ-033 cnt_en and cnt_clr SHALL never be high in the same cycle.

Reset
REQ-034 rst high SHALL immediately force IDLE, req_ready=0, cnt_clr=0, cnt_en=0, res_valid=0, res_data=0, res_id=0, busy=0, last_grant=NREQ-1, independent of clk.
REQ-035 Reset mid-window or mid-REPORT SHALL discard the result; first accept after release goes to requester 0 if requesting.

Verification
REQ-036 req_valid[0]=1, len=5, counter model incrementing on cnt_en -> req_ready[0] at T, cnt_clr at T+1, cnt_en T+2..T+6, res_valid at T+8 with res_data=5, res_id=0.
REQ-037 req_valid=4'b1111 held, res_ready=1 -> grants in order 0,1,2,3,0; no requester starved.
REQ-038 len=0 on requester 2 -> no cnt_en, res_data=0, res_id=2, res_valid at T+3.
REQ-039 abort in 3rd RUN cycle of len=10 -> cnt_en low next cycle, no res_valid, next grant goes to requester after aborted one.
REQ-040 res_ready low 20 cycles in REPORT -> res_valid, res_data, res_id stable, req_ready stays 0; release -> IDLE next cycle.
REQ-041 rst asserted mid-RUN without clock edge -> cnt_en, busy, res_valid all 0 immediately.

Source files
------------

// File: rtl/count_window_sched.sv
// Round-robin scheduler that lends a shared counter to one requester at a time
// for a window of N enabled cycles and reports the captured count back.
module count_window_sched #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     abort,
    output logic                     cnt_clr,
    output logic                     cnt_en,
    input  logic [CNT_W-1:0]         cnt_val,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [CNT_W-1:0]         res_data,
    input  logic                     res_ready,
    output logic                     busy
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_REPORT
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_last_grant;
    logic [ID_W-1:0]   r_id;
    logic [LEN_W-1:0]  r_len;
    logic              r_cnt_clr;
    logic              r_cnt_en;
    logic              r_res_valid;
    logic [ID_W-1:0]   r_res_id;
    logic [CNT_W-1:0]  r_res_data;
    logic              r_busy;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [LEN_W-1:0]  w_win_len;
    logic [NREQ-1:0]   w_req_ready;

    // Walk the requesters once, starting just after the last grant.
    always_comb begin : rr_search
        logic [ID_W-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = (r_last_grant == ID_W'(NREQ-1)) ? '0 : r_last_grant + 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
            v_idx = (v_idx == ID_W'(NREQ-1)) ? '0 : v_idx + 1'b1;
        end
    end

    always_comb begin
        w_win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == ID_W'(i)) w_win_len = req_len[i*LEN_W +: LEN_W];
        end
    end

    // NOTE: the accept pulse must be combinational so a request dropped before
    // the edge is never granted; it is gated by rst because it bypasses the flops.
    always_comb begin
        w_req_ready = '0;
        if (!rst && r_state == S_IDLE && w_found) w_req_ready[w_win] = 1'b1;
    end

    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(NREQ-1);
            r_id         <= '0;
            r_len        <= '0;
            r_cnt_clr    <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_data   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state      <= S_CLEAR;
                        r_last_grant <= w_win;
                        r_id         <= w_win;
                        r_len        <= w_win_len;
                        r_cnt_clr    <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_cnt_clr <= 1'b0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_len == '0) begin
                        r_state <= S_SETTLE;
                    end else begin
                        r_state  <= S_RUN;
                        r_cnt_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_cnt_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_len == LEN_W'(1)) begin
                        r_state  <= S_SETTLE;
                        r_cnt_en <= 1'b0;
                    end else begin
                        r_len <= r_len - 1'b1;
                    end
                end
                S_SETTLE: begin
                    // Counter has absorbed the last enable by now; sample it here.
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
                        r_res_data  <= cnt_val;
                        r_res_id    <= r_id;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt_clr   <= 1'b0;
                    r_cnt_en    <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign cnt_clr   = r_cnt_clr;
    assign cnt_en    = r_cnt_en;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_count_window_sched.sv
// Bench for count_window_sched: a timeline model predicts every output each
// cycle; directed scenarios pin grant order, latencies and captured counts.
module tb_count_window_sched;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;
    localparam int CNT_W = 16;
    localparam int ID_W  = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_ready;
    logic                  abort;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CNT_W-1:0]      cnt_val;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [CNT_W-1:0]      res_data;
    logic                  res_ready;
    logic                  busy;

    count_window_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .abort     (abort),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_val   (cnt_val),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared counter; starts at a non-zero value so a missing clear shows up.
    logic [CNT_W-1:0] cnt = 16'h1234;
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign cnt_val = cnt;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event logs filled by the compare process, read by directed scenarios.
    int grant_q[$];
    int grant_cyc_q[$];
    int res_cyc_q[$];
    int res_data_q[$];
    int res_id_q[$];
    int clr_cyc, first_en, last_en, en_count;

    task automatic clear_logs();
        grant_q.delete();
        grant_cyc_q.delete();
        res_cyc_q.delete();
        res_data_q.delete();
        res_id_q.delete();
        clr_cyc  = -1;
        first_en = -1;
        last_en  = -1;
        en_count = 0;
    endtask

    // Window model: position inside a window is cycles elapsed since accept.
    bit m_busy, m_rep, prev_rv;
    int m_d, m_len, m_id, m_last, m_data, pick;
    logic [NREQ-1:0] e_ready;
    logic e_clr, e_en, e_rv;
    logic [LEN_W-1:0] lv;

    function automatic int rr_pick(input logic [NREQ-1:0] rv, input int last);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (rv[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin : compare
        m_busy = 0; m_rep = 0; m_last = NREQ-1; prev_rv = 0;
        m_d = 0; m_len = 0; m_id = 0; m_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy  = 0;
                m_rep   = 0;
                m_last  = NREQ-1;
                prev_rv = 0;
            end else begin
                pick    = rr_pick(req_valid, m_last);
                e_ready = '0;
                e_clr   = 1'b0;
                e_en    = 1'b0;
                e_rv    = 1'b0;
                if (!m_busy) begin
                    if (pick >= 0) e_ready[pick] = 1'b1;
                end else if (m_rep) begin
                    e_rv = 1'b1;
                end else begin
                    e_clr = (m_d == 1);
                    e_en  = (m_d >= 2 && m_d <= m_len + 1);
                end
                check("req_ready", req_ready, e_ready);
                check("cnt_clr",   cnt_clr,   e_clr);
                check("cnt_en",    cnt_en,    e_en);
                check("busy",      busy,      m_busy);
                check("res_valid", res_valid, e_rv);
                if (e_rv) begin
                    check("res_id",   res_id,   m_id);
                    check("res_data", res_data, m_data);
                end

                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        grant_q.push_back(i);
                        grant_cyc_q.push_back(cyc);
                    end
                end
                if (cnt_clr) clr_cyc = cyc;
                if (cnt_en) begin
                    en_count++;
                    if (first_en < 0) first_en = cyc;
                    last_en = cyc;
                end
                if (res_valid && !prev_rv) begin
                    res_cyc_q.push_back(cyc);
                    res_data_q.push_back(int'(res_data));
                    res_id_q.push_back(int'(res_id));
                end
                prev_rv = res_valid;

                if (!m_busy) begin
                    if (pick >= 0) begin
                        lv     = req_len[pick*LEN_W +: LEN_W];
                        m_busy = 1;
                        m_rep  = 0;
                        m_d    = 1;
                        m_id   = pick;
                        m_last = pick;
                        m_len  = int'(lv);
                    end
                end else if (m_rep) begin
                    if (res_ready) begin
                        m_busy = 0;
                        m_rep  = 0;
                    end
                end else if (abort) begin
                    m_busy = 0;
                end else if (m_d == m_len + 2) begin
                    m_rep  = 1;
                    m_data = m_len;
                end else begin
                    m_d++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        for (int i = 0; i < budget && grant_q.size() < n; i++) tick();
        check({name, "_grant_wait"}, grant_q.size() >= n, 1);
    endtask

    task automatic wait_res(input int n, input int budget, input string name);
        for (int i = 0; i < budget && res_cyc_q.size() < n; i++) tick();
        check({name, "_res_wait"}, res_cyc_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("idle_wait", busy, 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0;
        int r;
        rst       = 1'b1;
        req_valid = 4'b0001;
        req_len   = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        clear_logs();
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_busy",      busy,      0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data",  res_data,  0);
        check("rst_res_id",    res_id,    0);
        check("rst_cnt_en",    cnt_en,    0);
        check("rst_cnt_clr",   cnt_clr,   0);
        req_valid = '0;
        rst       = 1'b0;
        tick();

        // Zero-length window on requester 2.
        clear_logs();
        set_len(2, 0);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        wait_grants(1, 20, "len0");
        req_valid = '0;
        wait_res(1, 30, "len0");
        if (grant_q.size() > 0 && res_cyc_q.size() > 0) begin
            t0 = grant_cyc_q[0];
            check("len0_grant_id", grant_q[0],    2);
            check("len0_en_count", en_count,      0);
            check("len0_res_cyc",  res_cyc_q[0],  t0 + 3);
            check("len0_res_data", res_data_q[0], 0);
            check("len0_res_id",   res_id_q[0],   2);
        end
        wait_idle(20);

        // Length 5 on requester 0: full latency profile.
        clear_logs();
        set_len(0, 5);
        req_valid = 4'b0001;
        wait_grants(1, 20, "len5");
        req_valid = '0;
        wait_res(1, 40, "len5");
        if (grant_q.size() > 0 && res_cyc_q.size() > 0) begin
            t0 = grant_cyc_q[0];
            check("len5_grant_id", grant_q[0],    0);
            check("len5_clr_cyc",  clr_cyc,       t0 + 1);
            check("len5_en_count", en_count,      5);
            check("len5_first_en", first_en,      t0 + 2);
            check("len5_last_en",  last_en,       t0 + 6);
            check("len5_res_cyc",  res_cyc_q[0],  t0 + 8);
            check("len5_res_data", res_data_q[0], 5);
            check("len5_res_id",   res_id_q[0],   0);
        end
        wait_idle(20);

        // Asynchronous reset in the middle of a run.
        clear_logs();
        set_len(1, 10);
        req_valid = 4'b0010;
        wait_grants(1, 20, "arst");
        req_valid = 4'b0001;
        for (int i = 0; i < 10 && en_count < 2; i++) tick();
        check("arst_in_run", cnt_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt_en",    cnt_en,    0);
        check("arst_busy",      busy,      0);
        check("arst_res_valid", res_valid, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_res_data",  res_data,  0);
        tick();
        tick();
        set_len(0, 1);
        set_len(1, 2);
        set_len(2, 3);
        set_len(3, 0);
        clear_logs();
        req_valid = 4'b1111;
        rst       = 1'b0;

        // All requesting: round-robin order from requester 0.
        wait_grants(5, 200, "rr");
        if (grant_q.size() >= 5) begin
            check("rr_g0", grant_q[0], 0);
            check("rr_g1", grant_q[1], 1);
            check("rr_g2", grant_q[2], 2);
            check("rr_g3", grant_q[3], 3);
            check("rr_g4", grant_q[4], 0);
        end
        req_valid = '0;
        wait_idle(50);

        // Abort in the third run cycle of a length-10 window.
        clear_logs();
        set_len(1, 10);
        req_valid = 4'b0010;
        wait_grants(1, 20, "abort");
        req_valid = '0;
        t0 = (grant_cyc_q.size() > 0) ? grant_cyc_q[0] : cyc;
        for (int i = 0; i < 20 && cyc < t0 + 4; i++) tick();
        check("abort_align", cyc, t0 + 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cnt_en",   cnt_en,   0);
        check("abort_busy",     busy,     0);
        check("abort_en_count", en_count, 3);
        req_valid = 4'b1111;
        wait_grants(2, 20, "abort_next");
        if (grant_q.size() >= 2) check("abort_next_id", grant_q[1], 2);
        check("abort_no_result", res_cyc_q.size(), 0);
        req_valid = '0;
        wait_idle(50);

        // Consumer stalls for 20 cycles in REPORT.
        clear_logs();
        set_len(3, 4);
        req_valid = 4'b1000;
        res_ready = 1'b0;
        wait_grants(1, 20, "stall");
        req_valid = 4'b1111;
        wait_res(1, 30, "stall");
        for (int i = 0; i < 20; i++) tick();
        check("stall_valid",  res_valid,      1);
        check("stall_data",   res_data,       4);
        check("stall_id",     res_id,         3);
        check("stall_grants", grant_q.size(), 1);
        res_ready = 1'b1;
        tick();
        check("stall_release_busy",  busy,      0);
        check("stall_release_valid", res_valid, 0);
        req_valid = '0;
        wait_idle(50);

        // Maximum length: no wrap of the window counter.
        clear_logs();
        set_len(0, 255);
        req_valid = 4'b0001;
        wait_grants(1, 20, "max");
        req_valid = '0;
        wait_res(1, 300, "max");
        if (grant_q.size() > 0 && res_cyc_q.size() > 0) begin
            t0 = grant_cyc_q[0];
            check("max_en_count", en_count,      255);
            check("max_res_cyc",  res_cyc_q[0],  t0 + 258);
            check("max_res_data", res_data_q[0], 255);
        end
        wait_idle(20);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3)       set_len(i, 255);
                else if (r < 12) set_len(i, 0);
                else             set_len(i, $urandom_range(1, 12));
            end
            abort     = ($urandom_range(0, 29) == 0);
            res_ready = ($urandom_range(0, 1) == 1);
            if (n == 2000) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        abort     = 1'b0;
        res_ready = 1'b1;
        wait_idle(400);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
